cluster_pe_ctrl: RTL and testbench
==================================

# cluster_pe_ctrl

Sequencer for one `cluster_PE` node of the k-d tree clustering datapath. It drives every PE control strobe (`en`, `init`, `start_iter`, `receive_point`, `inc`, `update`, `sorting`, `parent_switch`, `child_switch`, `next_level`) through a complete clustering job:

- init;
- then repeated iterations of point accumulation, centre update and tree sort;
- until the PE reports `stable`.

It sits between the job-level top controller and point stream on one side and a single `cluster_PE` instance on the other.

## Interface
Parameters:
- `MAX_DEPTH`, 16, tree depth; also the number of sort cycles per iteration
- `DEPTH_SIZE`, `$clog2(MAX_DEPTH)`, width of the depth field
- `CNT_W`, 16, width of the point counter
- `MAX_ITER`, 64, iteration cap (used only with `CLUSTER_CTRL_ITER_LIMIT_EN`)
- `ITER_W`, `$clog2(MAX_ITER)+1`, width of `iter_count`

Ports:
- `clk`  in  1  clock; rising edge
- `rst`  in  1  reset; asynchronous, active-low
- `start`  in  1  job request; sampled only in IDLE
- `num_points`  in  CNT_W  points per iteration; captured on accepted `start`
- `pt_valid`  in  1  point source has a point on the PE `point_in` bus
- `pt_ready`  out  1  controller accepts a point this cycle
- `pe_stable`  in  1  PE `stable` output
- `pe_switch_en`  in  1  PE `switch_en` output
- `pe_en`, `pe_init`, `pe_start_iter`, `pe_receive_point`, `pe_inc`, `pe_update`, `pe_sorting`, `pe_parent_switch`, `pe_child_switch`, `pe_next_level`  out  1 each  PE strobes
- `busy`  out  1  job in progress
- `done`  out  1  one-cycle job completion pulse
- `timeout`  out  1  job ended on the iteration cap; held until the next `start`
- `iter_count`  out  ITER_W  completed non-stable iterations

## Operation
State machine: IDLE, INIT, ITER, RECV, INC, UPD, SORT, CHECK, FIN.

- **IDLE**
  - `start` = 1: capture `num_points`, clear `iter_count` and `timeout`, go to INIT.
  - `start` is ignored in every other state.
- **INIT**: `pe_init` = 1 for one cycle, then go to ITER.
- **ITER**: `pe_start_iter` = 1 for one cycle; clear the point counter.
  - Go to RECV.
  - Go to UPD instead if the captured `num_points` is 0.
- **RECV**: `pt_ready` = 1.
  - On `pt_valid` & `pt_ready`: `pe_receive_point` = 1 and `pe_next_level` = 1 in that same cycle (combinational), then go to INC.
  - With no `pt_valid`, stay in RECV; there is no timeout.
- **INC**: `pe_inc` = 1 for one cycle; point counter +1.
  - Counter reaches `num_points`: go to UPD.
  - Otherwise: go to RECV.
- **UPD**: `pe_update` = 1 for one cycle, then go to SORT.
- **SORT**: `pe_sorting` = 1 for exactly MAX_DEPTH cycles; sort counter `s` runs from 0 to MAX_DEPTH-1.
  - `pe_parent_switch` = `pe_switch_en` & (`s` even).
  - `pe_child_switch` = `pe_switch_en` & (`s` odd).
  - Never both in one cycle.
  - After `s` = MAX_DEPTH-1, go to CHECK.
- **CHECK**
  - `pe_stable` = 1: go to FIN.
  - Otherwise: `iter_count` +1 (saturating), then go to ITER.
- **FIN**: `done` = 1 for one cycle, then go to IDLE.
- `pe_en` = `busy` = (state ≠ IDLE).
- All strobes not listed for a state are 0.

## Timing
- Reset values: state IDLE; every output 0, including `iter_count`.
- Reset is asynchronous. Asserting `rst` mid-job aborts immediately: outputs drop to 0 with no `done`, and the PE must be re-initialised by a new job.
- `start` at edge *n*: `busy` and `pe_init` high in cycle *n*+1.
- `pe_start_iter` follows `pe_init` by 1 cycle.
- Per point: minimum 2 cycles (RECV accept, INC).
- Back-to-back `pt_valid` yields one point every 2 cycles.
- Iteration length: 1 + 2·N + 1 + MAX_DEPTH + 1 cycles at full point rate.
- `pe_stable` is sampled only in CHECK, i.e. 1 cycle after the last sort cycle.
- A `pt_valid` arriving outside RECV is not accepted; the source must hold it.

## Configuration
- `CLUSTER_CTRL_ITER_LIMIT_EN` defined:
  - In CHECK with `pe_stable` = 0 and `iter_count` = MAX_ITER-1: set `timeout` = 1 and go to FIN.
  - `done` still pulses.
- Undefined:
  - No cap; iterations continue until `pe_stable`.
  - `timeout` is tied to 0.
  - `iter_count` saturates at all-ones.

## Test plan
- Reset mid-SORT → all outputs 0 within the same cycle; the next `start` gives `pe_init` at +1 cycle.
- `num_points` = 3, `pt_valid` held high, `pe_stable` = 1 at first CHECK →
  - `pe_receive_point` pulses at 3 RECV cycles, 2 cycles apart;
  - 3 `pe_inc` pulses;
  - 1 `pe_update`;
  - 16 `pe_sorting` cycles;
  - `done` at cycle 2+1+6+1+16+1+1;
  - `iter_count` = 0.
- `pt_valid` stalled 5 cycles in RECV → `pt_ready` stays 1 and no PE strobe other than `pe_sorting`-free `pe_en` is asserted.
- `pe_switch_en` = 1 throughout SORT → `pe_parent_switch` high on `s` = 0, 2, …, 14 and `pe_child_switch` high on `s` = 1, 3, …, 15; never both high.
- `num_points` = 0 → ITER goes directly to UPD; `pt_ready` is never asserted.
- With `CLUSTER_CTRL_ITER_LIMIT_EN` and `MAX_ITER` = 4, `pe_stable` held 0 → `done` and `timeout` = 1 after the 4th iteration, `iter_count` = 3. Without the macro, iterations continue.

Source files
------------

// File: rtl/cluster_pe_ctrl.sv
// cluster_pe_ctrl
// ---------------
// Sequencer for a single cluster_PE node of the k-d tree clustering datapath.
// A job runs one PE init, then repeats iterations of point accumulation,
// centre update and tree sort until the PE reports stable.
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-low reset
//   start, num_points   job request (sampled in IDLE) and points per iteration
//   pt_valid, pt_ready  point-stream handshake, a point moves when both are high
//   pe_stable           PE stable flag, sampled once per iteration after sorting
//   pe_switch_en        PE switch_en flag, gates the parent/child switch strobes
//   pe_*                PE control strobes
//   busy, done          job in progress, one-cycle completion pulse
//   timeout             job ended on the iteration cap, held until next start
//   iter_count          completed non-stable iterations of the current job
//
// Build option
//   CLUSTER_CTRL_ITER_LIMIT_EN  when defined, a job that is still unstable at
//   iteration MAX_ITER ends with timeout set. When undefined there is no cap,
//   timeout is tied low and iter_count saturates at all-ones.

module cluster_pe_ctrl #(
  parameter int MAX_DEPTH  = 16,
  parameter int DEPTH_SIZE = $clog2(MAX_DEPTH),
  parameter int CNT_W      = 16,
  parameter int MAX_ITER   = 64,
  parameter int ITER_W     = $clog2(MAX_ITER) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  num_points,
  input  logic              pt_valid,
  output logic              pt_ready,
  input  logic              pe_stable,
  input  logic              pe_switch_en,
  output logic              pe_en,
  output logic              pe_init,
  output logic              pe_start_iter,
  output logic              pe_receive_point,
  output logic              pe_inc,
  output logic              pe_update,
  output logic              pe_sorting,
  output logic              pe_parent_switch,
  output logic              pe_child_switch,
  output logic              pe_next_level,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic [ITER_W-1:0] iter_count
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_INIT,
    S_ITER,
    S_RECV,
    S_INC,
    S_UPD,
    S_SORT,
    S_CHECK,
    S_FIN
  } state_t;

  localparam logic [DEPTH_SIZE-1:0] SORT_LAST = DEPTH_SIZE'(MAX_DEPTH - 1);

  state_t                r_state;
  logic [CNT_W-1:0]      r_num_points;
  logic [CNT_W-1:0]      r_pt_cnt;
  logic [DEPTH_SIZE-1:0] r_sort;
  logic [ITER_W-1:0]     r_iter;

  logic [CNT_W-1:0]      w_pt_next;
  logic                  w_accept;

  assign w_pt_next = r_pt_cnt + 1'b1;
  assign w_accept  = (r_state == S_RECV) && pt_valid;

`ifdef CLUSTER_CTRL_ITER_LIMIT_EN
  logic r_timeout;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_num_points <= '0;
      r_pt_cnt     <= '0;
      r_sort       <= '0;
      r_iter       <= '0;
`ifdef CLUSTER_CTRL_ITER_LIMIT_EN
      r_timeout    <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_num_points <= num_points;
            r_iter       <= '0;
`ifdef CLUSTER_CTRL_ITER_LIMIT_EN
            r_timeout    <= 1'b0;
`endif
            r_state      <= S_INIT;
          end
        end
        S_INIT: r_state <= S_ITER;
        S_ITER: begin
          r_pt_cnt <= '0;
          // An empty point set skips straight to the centre update.
          r_state  <= (r_num_points == '0) ? S_UPD : S_RECV;
        end
        S_RECV: begin
          if (pt_valid) r_state <= S_INC;
        end
        S_INC: begin
          r_pt_cnt <= w_pt_next;
          r_state  <= (w_pt_next == r_num_points) ? S_UPD : S_RECV;
        end
        S_UPD: begin
          r_sort  <= '0;
          r_state <= S_SORT;
        end
        S_SORT: begin
          r_sort <= r_sort + 1'b1;
          if (r_sort == SORT_LAST) r_state <= S_CHECK;
        end
        S_CHECK: begin
          if (pe_stable) begin
            r_state <= S_FIN;
`ifdef CLUSTER_CTRL_ITER_LIMIT_EN
          end else if (r_iter == ITER_W'(MAX_ITER - 1)) begin
            // iter_count is left at MAX_ITER-1 so the cap point is visible.
            r_timeout <= 1'b1;
            r_state   <= S_FIN;
          end else begin
            r_iter  <= r_iter + 1'b1;
            r_state <= S_ITER;
          end
`else
          end else begin
            if (r_iter != {ITER_W{1'b1}}) r_iter <= r_iter + 1'b1;
            r_state <= S_ITER;
          end
`endif
        end
        S_FIN:   r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Strobes are decoded from the state register so an asynchronous reset
  // clears all of them in the same cycle.
  assign busy             = (r_state != S_IDLE);
  assign pe_en            = busy;
  assign pe_init          = (r_state == S_INIT);
  assign pe_start_iter    = (r_state == S_ITER);
  assign pt_ready         = (r_state == S_RECV);
  assign pe_receive_point = w_accept;
  assign pe_next_level    = w_accept;
  assign pe_inc           = (r_state == S_INC);
  assign pe_update        = (r_state == S_UPD);
  assign pe_sorting       = (r_state == S_SORT);
  // Even sort steps switch at the parent, odd steps at the child.
  assign pe_parent_switch = pe_sorting && pe_switch_en && !r_sort[0];
  assign pe_child_switch  = pe_sorting && pe_switch_en &&  r_sort[0];
  assign done             = (r_state == S_FIN);
  assign iter_count       = r_iter;

`ifdef CLUSTER_CTRL_ITER_LIMIT_EN
  assign timeout = r_timeout;
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_cluster_pe_ctrl.sv
// Self-checking bench for cluster_pe_ctrl. Expected behaviour comes from a
// cycle-level event model built from the sequencing rules: a job is init,
// then per iteration one start_iter, N accept/inc pairs, one update,
// MAX_DEPTH sort steps and one stability check.

module tb_cluster_pe_ctrl;

  localparam int D        = 16;
  localparam int CNT_W    = 16;
  localparam int MAX_ITER = 64;
  localparam int ITER_W   = $clog2(MAX_ITER) + 1;

  logic              clk;
  logic              rst;
  logic              start;
  logic [CNT_W-1:0]  num_points;
  logic              pt_valid;
  logic              pt_ready;
  logic              pe_stable;
  logic              pe_switch_en;
  logic              pe_en, pe_init, pe_start_iter, pe_receive_point, pe_inc;
  logic              pe_update, pe_sorting, pe_parent_switch, pe_child_switch;
  logic              pe_next_level, busy, done, timeout;
  logic [ITER_W-1:0] iter_count;

  int vectors     = 0;
  int miscompares = 0;

  logic [13:0] all_bits;
  logic [9:0]  strobes;
  assign all_bits = {pt_ready, pe_en, pe_init, pe_start_iter, pe_receive_point, pe_inc,
                     pe_update, pe_sorting, pe_parent_switch, pe_child_switch,
                     pe_next_level, busy, done, timeout};
  assign strobes  = {pe_init, pe_start_iter, pe_receive_point, pe_inc, pe_update,
                     pe_sorting, pe_parent_switch, pe_child_switch, pe_next_level, done};

  cluster_pe_ctrl #(
    .MAX_DEPTH(D), .CNT_W(CNT_W), .MAX_ITER(MAX_ITER)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .num_points(num_points),
    .pt_valid(pt_valid), .pt_ready(pt_ready), .pe_stable(pe_stable),
    .pe_switch_en(pe_switch_en), .pe_en(pe_en), .pe_init(pe_init),
    .pe_start_iter(pe_start_iter), .pe_receive_point(pe_receive_point),
    .pe_inc(pe_inc), .pe_update(pe_update), .pe_sorting(pe_sorting),
    .pe_parent_switch(pe_parent_switch), .pe_child_switch(pe_child_switch),
    .pe_next_level(pe_next_level), .busy(busy), .done(done),
    .timeout(timeout), .iter_count(iter_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Runs one job with N points, going stable at the K-th check. Cycle 1 is
  // the cycle in which start is presented.
  task automatic run_job(input int n, input int k, input int vpct, input int swpct);
    int cyc, iters, rx_iter, rx_tot, sort_left, sidx;
    bit e_init, e_iter, e_ready, e_inc, e_upd, e_chk, e_done, e_recv, e_sort;
    bit n_ready, n_inc, n_upd, n_chk, n_iter, n_done, finished;
    logic [10:0] got, exp;
    num_points = CNT_W'(n); pt_valid = 1'b0; pe_stable = 1'b0; pe_switch_en = 1'b0;
    start = 1'b1;
    tick;
    start = 1'b0;
    cyc = 2; iters = 0; rx_iter = 0; rx_tot = 0; sort_left = 0; sidx = 0;
    e_init = 1; e_iter = 0; e_ready = 0; e_inc = 0; e_upd = 0; e_chk = 0; e_done = 0;
    finished = 0;
    while (!finished && cyc < 6000) begin
      pt_valid     = ($urandom_range(0, 99) < vpct);
      pe_switch_en = ($urandom_range(0, 99) < swpct);
      pe_stable    = (iters >= k);
      #1;
      e_recv = e_ready & pt_valid;
      e_sort = (sort_left > 0);
      exp = {e_init, e_iter, e_ready, e_recv, e_recv, e_inc, e_upd, e_sort,
             e_sort & pe_switch_en & (sidx % 2 == 0),
             e_sort & pe_switch_en & (sidx % 2 == 1), e_done};
      got = {pe_init, pe_start_iter, pt_ready, pe_receive_point, pe_next_level, pe_inc,
             pe_update, pe_sorting, pe_parent_switch, pe_child_switch, done};
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL strobes n=%0d k=%0d cycle %0d: got %b, expected %b", n, k, cyc, got, exp);
      end
      vectors++;
      if (pe_en !== 1'b1 || busy !== 1'b1) begin
        miscompares++;
        $display("FAIL busy cycle %0d: pe_en=%b busy=%b, expected 1", cyc, pe_en, busy);
      end
      if (e_iter) begin iters++; rx_iter = 0; end
      if (e_recv) begin rx_iter++; rx_tot++; end
      n_ready = (e_ready & !pt_valid) | (e_inc & (rx_iter < n)) | (e_iter & (n > 0));
      n_inc   = e_recv;
      n_upd   = (e_inc & (rx_iter == n)) | (e_iter & (n == 0));
      n_chk   = (sort_left == 1);
      n_done  = e_chk & (iters >= k);
      n_iter  = e_init | (e_chk & (iters < k));
      if (e_upd) begin
        sort_left = D; sidx = 0;
      end else if (sort_left > 0) begin
        sort_left--; sidx++;
      end
      if (e_done || done) finished = 1;
      else begin
        tick; cyc++;
        e_init = 0; e_iter = n_iter; e_ready = n_ready; e_inc = n_inc;
        e_upd = n_upd; e_chk = n_chk; e_done = n_done;
      end
    end
    vectors++;
    if (!finished) begin
      miscompares++;
      $display("FAIL job_bound: done not seen by cycle %0d", cyc);
    end
    vectors++;
    if (rx_tot !== k * n) begin
      miscompares++;
      $display("FAIL points_total: got %0d, expected %0d", rx_tot, k * n);
    end
    if (vpct == 100) begin
      vectors++;
      if (cyc !== 2 + k * (3 + 2 * n + D) + 1) begin
        miscompares++;
        $display("FAIL done_cycle: got %0d, expected %0d", cyc, 2 + k * (3 + 2 * n + D) + 1);
      end
    end
    vectors++;
    if (iter_count !== ITER_W'(k - 1)) begin
      miscompares++;
      $display("FAIL iter_count: got %0d, expected %0d", iter_count, k - 1);
    end
    vectors++;
    if (timeout !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout: got %b, expected 0", timeout);
    end
    pt_valid = 1'b0; pe_switch_en = 1'b0; pe_stable = 1'b0;
    tick;
    vectors++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL done_pulse: done=%b busy=%b after FIN, expected 0 0", done, busy);
    end
  endtask

  task automatic test_reset;
    rst = 1'b0; start = 1'b0; num_points = '0; pt_valid = 1'b0;
    pe_stable = 1'b0; pe_switch_en = 1'b0;
    #1;
    vectors++;
    if (all_bits !== '0 || iter_count !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %b/%0d, expected all 0", all_bits, iter_count);
    end
    tick; tick;
    rst = 1'b1;
    tick;
    vectors++;
    if (all_bits !== '0 || iter_count !== '0) begin
      miscompares++;
      $display("FAIL idle_after_reset: got %b/%0d, expected all 0", all_bits, iter_count);
    end
  endtask

  task automatic test_full_rate;
    run_job(3, 1, 100, 100);
    run_job(2, 3, 100, 0);
  endtask

  task automatic test_zero_points;
    run_job(0, 2, 100, 50);
  endtask

  task automatic test_random;
    for (int j = 0; j < 6; j++)
      run_job($urandom_range(0, 5), $urandom_range(1, 3), $urandom_range(30, 90),
              $urandom_range(0, 100));
  endtask

  task automatic test_stall;
    int c;
    num_points = CNT_W'(2); pt_valid = 1'b0; pe_stable = 1'b1; pe_switch_en = 1'b0;
    start = 1'b1;
    tick;
    start = 1'b0;
    c = 0;
    while (pt_ready !== 1'b1 && c < 10) begin tick; c++; end
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (pt_ready !== 1'b1 || strobes !== '0 || pe_en !== 1'b1) begin
        miscompares++;
        $display("FAIL stall cycle %0d: ready=%b strobes=%b en=%b, expected 1 0 1",
                 i, pt_ready, strobes, pe_en);
      end
      tick;
    end
    pt_valid = 1'b1;
    c = 0;
    while (done !== 1'b1 && c < 200) begin tick; c++; end
    vectors++;
    if (done !== 1'b1) begin
      miscompares++;
      $display("FAIL stall_finish: done=%b, expected 1", done);
    end
    pt_valid = 1'b0;
    tick;
  endtask

  task automatic test_back_to_back;
    int c;
    num_points = CNT_W'(1); pt_valid = 1'b1; pe_stable = 1'b1; pe_switch_en = 1'b0;
    start = 1'b1;
    tick;
    c = 2;
    num_points = CNT_W'(5);
    while (done !== 1'b1 && c < 200) begin tick; c++; end
    vectors++;
    if (c !== 2 + (3 + 2 + D) + 1) begin
      miscompares++;
      $display("FAIL b2b_first_done: got cycle %0d, expected %0d", c, 2 + (3 + 2 + D) + 1);
    end
    tick;
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_idle: busy=%b, expected 0", busy);
    end
    tick;
    vectors++;
    if (pe_init !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_restart: pe_init=%b, expected 1", pe_init);
    end
    start = 1'b0;
    c = 2;
    while (done !== 1'b1 && c < 200) begin tick; c++; end
    vectors++;
    if (c !== 2 + (3 + 10 + D) + 1) begin
      miscompares++;
      $display("FAIL b2b_second_done: got cycle %0d, expected %0d", c, 2 + (3 + 10 + D) + 1);
    end
    pt_valid = 1'b0;
    tick;
  endtask

  task automatic test_reset_mid_sort;
    int c, started;
    num_points = '0; pt_valid = 1'b0; pe_stable = 1'b0; pe_switch_en = 1'b1;
    start = 1'b1;
    tick;
    start = 1'b0;
    c = 0; started = 0;
    while (!(started == 3 && pe_sorting === 1'b1) && c < 500) begin
      if (pe_start_iter === 1'b1) started++;
      tick; c++;
    end
    tick; tick;
    vectors++;
    if (pe_sorting !== 1'b1 || iter_count !== ITER_W'(2)) begin
      miscompares++;
      $display("FAIL pre_reset: sorting=%b iter_count=%0d, expected 1 2", pe_sorting, iter_count);
    end
    #3;
    rst = 1'b0;
    #1;
    vectors++;
    if (all_bits !== '0 || iter_count !== '0) begin
      miscompares++;
      $display("FAIL mid_sort_reset: got %b/%0d, expected all 0", all_bits, iter_count);
    end
    tick;
    rst = 1'b1;
    pe_stable = 1'b1;
    start = 1'b1;
    tick;
    start = 1'b0;
    vectors++;
    if (pe_init !== 1'b1 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL restart_init: pe_init=%b busy=%b, expected 1 1", pe_init, busy);
    end
    tick;
    vectors++;
    if (pe_start_iter !== 1'b1) begin
      miscompares++;
      $display("FAIL restart_iter: pe_start_iter=%b, expected 1", pe_start_iter);
    end
    c = 0;
    while (done !== 1'b1 && c < 200) begin tick; c++; end
    pe_stable = 1'b0; pe_switch_en = 1'b0;
    tick;
  endtask

  task automatic test_iter_cap;
    int c, started;
    logic [ITER_W-1:0] sat;
    sat = '1;
    num_points = '0; pt_valid = 1'b0; pe_stable = 1'b0; pe_switch_en = 1'b0;
    start = 1'b1;
    tick;
    start = 1'b0;
    c = 0; started = 0;
`ifdef CLUSTER_CTRL_ITER_LIMIT_EN
    while (done !== 1'b1 && c < 5000) begin
      if (pe_start_iter === 1'b1) started++;
      tick; c++;
    end
    vectors++;
    if (done !== 1'b1 || started !== MAX_ITER || timeout !== 1'b1 ||
        iter_count !== ITER_W'(MAX_ITER - 1)) begin
      miscompares++;
      $display("FAIL iter_cap: done=%b iters=%0d timeout=%b iter_count=%0d, expected 1 %0d 1 %0d",
               done, started, timeout, iter_count, MAX_ITER, MAX_ITER - 1);
    end
    tick; tick;
    vectors++;
    if (timeout !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_hold: timeout=%b busy=%b, expected 1 0", timeout, busy);
    end
`else
    while (started < 130 && done !== 1'b1 && c < 5000) begin
      tick; c++;
      if (pe_start_iter === 1'b1) started++;
    end
    vectors++;
    if (started !== 130 || iter_count !== sat || timeout !== 1'b0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL no_cap: iters=%0d iter_count=%0d timeout=%b busy=%b, expected 130 %0d 0 1",
               started, iter_count, timeout, busy, sat);
    end
    pe_stable = 1'b1;
    c = 0;
    while (done !== 1'b1 && c < 100) begin tick; c++; end
    vectors++;
    if (done !== 1'b1 || iter_count !== sat) begin
      miscompares++;
      $display("FAIL no_cap_finish: done=%b iter_count=%0d, expected 1 %0d", done, iter_count, sat);
    end
    pe_stable = 1'b0;
    tick;
`endif
  endtask

  initial begin
    test_reset;
    test_full_rate;
    test_zero_points;
    test_stall;
    test_back_to_back;
    test_random;
    test_reset_mid_sort;
    test_iter_cap;
    run_job(1, 1, 100, 100);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
